// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//   Shares the single register_file write port between N_REQ writeback
//   sources using round-robin arbitration. The grant drives a registered
//   output stage. A per-register busy scoreboard stalls the issue stage
//   while any operand or destination still has a write outstanding.
//   Register 31 is read-only in register_file, so it is never tracked.
//
// Handshake: requester i holds req_valid/req_rd/req_data stable until it
//   sees req_ready[i]=1 in a cycle. The write is accepted on the rising edge
//   that ends that cycle. req_ready is one-hot or zero, and it does not
//   depend on the issue_* inputs.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   req_valid/req_rd/req_data   per-requester writeback (packed slices)
//   req_ready                   one-hot grant
//   issue_valid, issue_rs1/rs2/rd, issue_rs_en, issue_rd_en  issue probe
//   issue_stall                 instruction must not issue this cycle
//   register_write_valid, write_reg, reg_write_data  to register_file
//   pending_count               number of busy registers
module regfile_writeback_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [5*N_REQ-1:0]      req_rd,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rs1,
  input  logic [4:0]              issue_rs2,
  input  logic [4:0]              issue_rd,
  input  logic [1:0]              issue_rs_en,
  input  logic                    issue_rd_en,
  output logic                    issue_stall,
  output logic                    register_write_valid,
  output logic [4:0]              write_reg,
  output logic [DATA_W-1:0]       reg_write_data,
  output logic [5:0]              pending_count
);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]       busy_q, busy_d;  // bit 31 is held at 0
  logic              wr_valid_q, wr_valid_d;
  logic [4:0]        wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [5:0]        pending_q, pending_d;

  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_idx;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              issue_acc, set_en, clr_en, inc, dec;

  // Rotating priority: scan from rr_ptr upward and take the first valid request.
  always_comb begin : arb
    int idx;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    sel_rd    = '0;
    sel_data  = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = idx[PTR_W-1:0];
        sel_rd   = req_rd[5*idx +: 5];
        sel_data = req_data[DATA_W*idx +: DATA_W];
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // busy_q[31] is always 0, so index 31 never stalls.
  assign issue_stall = issue_valid &&
                       ((issue_rs_en[0] && busy_q[issue_rs1]) ||
                        (issue_rs_en[1] && busy_q[issue_rs2]) ||
                        (issue_rd_en    && busy_q[issue_rd]));

  assign issue_acc = issue_valid && !issue_stall;
  assign set_en    = issue_acc && issue_rd_en && (issue_rd != 5'd31);
  // The clear coincides with the register_file commit of the staged write.
  assign clr_en    = wr_valid_q;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_valid_d = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    if (gnt_any) begin
      rr_ptr_d   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      wr_valid_d = (sel_rd != 5'd31);
      wr_reg_d   = sel_rd;
      wr_data_d  = sel_data;
    end
  end

  // The set is applied after the clear, so the set wins on a shared index.
  // An accepted set always targets a non-busy register, because a busy rd
  // stalls. A clear only counts when it really drops a set bit that is not
  // set again on the same edge. With this, pending_count tracks popcount(busy).
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[wr_reg_q] = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
    busy_d[31] = 1'b0;
    inc       = set_en;
    dec       = clr_en && busy_q[wr_reg_q] && !(set_en && (issue_rd == wr_reg_q));
    pending_d = pending_q + {5'b0, inc} - {5'b0, dec};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      busy_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      pending_q  <= pending_d;
    end
  end

  assign register_write_valid = wr_valid_q;
  assign write_reg            = wr_reg_q;
  assign reg_write_data       = wr_data_q;
  assign pending_count        = pending_q;

endmodule
